// File: rtl/neuron_alu.sv
// neuron_alu: four-input MAC neuron with saturating accumulator and clamped activation.
//   clk, rst         : clock, asynchronous active-high reset
//   clear            : zero accumulator and overflow flag (wins over accumulate)
//   accumulate       : add registered partial sum into the accumulator
//   weight1..weight4 : signed 4-bit weights
//   input1..input4   : unsigned 4-bit activations
//   bias             : signed 4-bit bias, scaled by 16 before the output shift
//   ALUOutput        : registered activation, clamp(((acc + bias*16) >>> OUT_SHIFT) + OUT_OFFSET, 0, 15)
//   acc_out          : accumulator value
//   overflow         : sticky saturation flag
module neuron_alu #(
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned OUT_SHIFT  = 5,
  parameter int          OUT_OFFSET = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        accumulate,
  input  logic signed [3:0]           weight1,
  input  logic signed [3:0]           weight2,
  input  logic signed [3:0]           weight3,
  input  logic signed [3:0]           weight4,
  input  logic        [3:0]           input1,
  input  logic        [3:0]           input2,
  input  logic        [3:0]           input3,
  input  logic        [3:0]           input4,
  input  logic signed [3:0]           bias,
  output logic        [3:0]           ALUOutput,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        overflow
);

  localparam int unsigned PW = 9;              // product width
  localparam int unsigned SW = 11;             // partial-sum width
  localparam int unsigned XW = ACC_WIDTH + 1;  // accumulate / total width
  localparam int unsigned TW = ACC_WIDTH + 2;  // width after offset add

  localparam logic signed [XW-1:0] ACC_MAX  = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] ACC_MIN  = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [TW-1:0] OFFSET_T = TW'(OUT_OFFSET);
  localparam logic signed [TW-1:0] ACT_MAX  = TW'(15);

  // Unsigned activation times signed weight, both widened to the product width.
  function automatic logic signed [PW-1:0] mul(input logic [3:0] a, input logic signed [3:0] w);
    logic signed [PW-1:0] a_w;
    logic signed [PW-1:0] w_w;
    a_w = {5'b00000, a};
    w_w = {{5{w[3]}}, w};
    return a_w * w_w;
  endfunction

  function automatic logic signed [SW-1:0] sx_p(input logic signed [PW-1:0] p);
    return {{(SW-PW){p[PW-1]}}, p};
  endfunction

  logic signed [PW-1:0]        p1, p2, p3, p4;
  logic signed [SW-1:0]        psum;
  logic signed [ACC_WIDTH-1:0] acc;

  // Stage 1: products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      p4 <= '0;
    end else begin
      p1 <= mul(input1, weight1);
      p2 <= mul(input2, weight2);
      p3 <= mul(input3, weight3);
      p4 <= mul(input4, weight4);
    end
  end

  // Stage 2: partial sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum <= '0;
    end else begin
      psum <= sx_p(p1) + sx_p(p2) + sx_p(p3) + sx_p(p4);
    end
  end

  // Saturating add of the partial sum into the accumulator
  logic signed [XW-1:0]        acc_x;
  logic signed [XW-1:0]        psum_x;
  logic signed [XW-1:0]        sum_x;
  logic signed [ACC_WIDTH-1:0] acc_sat_c;
  logic                        sat_hit_c;

  always_comb begin
    acc_x     = {acc[ACC_WIDTH-1], acc};
    psum_x    = {{(XW-SW){psum[SW-1]}}, psum};
    sum_x     = acc_x + psum_x;
    acc_sat_c = sum_x[ACC_WIDTH-1:0];
    sat_hit_c = 1'b0;
    if (sum_x > ACC_MAX) begin
      acc_sat_c = ACC_MAX[ACC_WIDTH-1:0];
      sat_hit_c = 1'b1;
    end else if (sum_x < ACC_MIN) begin
      acc_sat_c = ACC_MIN[ACC_WIDTH-1:0];
      sat_hit_c = 1'b1;
    end
  end

  // Accumulator and sticky overflow; clear has priority over accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (accumulate) begin
      acc      <= acc_sat_c;
      overflow <= overflow | sat_hit_c;
    end
  end

  assign acc_out = acc;

  // Activation: bias scaled by 16, arithmetic shift (floor), offset, clamp to 0..15
  logic signed [XW-1:0] bias_x;
  logic signed [XW-1:0] total_c;
  logic signed [XW-1:0] shifted_c;
  logic signed [TW-1:0] biased_c;
  logic        [3:0]    act_c;

  always_comb begin
    bias_x    = {{(XW-4){bias[3]}}, bias};
    total_c   = {acc[ACC_WIDTH-1], acc} + (bias_x <<< 4);
    shifted_c = total_c >>> OUT_SHIFT;
    biased_c  = {shifted_c[XW-1], shifted_c} + OFFSET_T;
    act_c     = biased_c[3:0];
    if (biased_c < 0) begin
      act_c = 4'd0;
    end else if (biased_c > ACT_MAX) begin
      act_c = 4'd15;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUOutput <= 4'd0;
    end else begin
      ALUOutput <= act_c;
    end
  end

endmodule

// File: tb/tb_neuron_alu.sv
// tb_neuron_alu: table-driven, directed and randomized checks of neuron_alu
// against an integer reference model of the accumulate/activation rules.
module tb_neuron_alu;

  localparam int ACC_MAXV = 32767;
  localparam int ACC_MINV = -32768;

  logic               clk;
  logic               rst;
  logic               clear;
  logic               accumulate;
  logic signed [3:0]  w [4];
  logic        [3:0]  in_a [4];
  logic signed [3:0]  bias;
  logic        [3:0]  alu;
  logic signed [15:0] acc_out;
  logic               overflow;

  neuron_alu dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accumulate (accumulate),
    .weight1    (w[0]),
    .weight2    (w[1]),
    .weight3    (w[2]),
    .weight4    (w[3]),
    .input1     (in_a[0]),
    .input2     (in_a[1]),
    .input3     (in_a[2]),
    .input4     (in_a[3]),
    .bias       (bias),
    .ALUOutput  (alu),
    .acc_out    (acc_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_acc = 0;
  int m_ov  = 0;

  typedef struct {
    int i[4];
    int wt[4];
    int b;
    int exp_acc;
    int exp_alu;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_psum();
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(in_a[k]) * int'(w[k]);
    return s;
  endfunction

  function automatic int ref_alu(input int a, input int b);
    int t = a + b * 16;
    int s;
    if (t >= 0) s = t / 32;
    else        s = -((-t + 31) / 32);
    s += 8;
    if (s < 0)  s = 0;
    if (s > 15) s = 15;
    return s;
  endfunction

  function automatic void set_ops(input int i0, input int i1, input int i2, input int i3,
                                  input int w0, input int w1, input int w2, input int w3,
                                  input int b);
    in_a[0] = 4'(i0); in_a[1] = 4'(i1); in_a[2] = 4'(i2); in_a[3] = 4'(i3);
    w[0] = 4'(w0); w[1] = 4'(w1); w[2] = 4'(w2); w[3] = 4'(w3);
    bias = 4'(b);
  endfunction

  // One clock edge with given controls; operands must have been held for >= 3 edges
  // before any accumulate so the pipeline holds their partial sum.
  task automatic run_edge(input logic c, input logic a, input string tag);
    int e_alu;
    int s;
    clear      = c;
    accumulate = a;
    e_alu = ref_alu(m_acc, int'(bias));
    if (c) begin
      m_acc = 0;
      m_ov  = 0;
    end else if (a) begin
      s = m_acc + ref_psum();
      if (s > ACC_MAXV)      begin m_acc = ACC_MAXV; m_ov = 1; end
      else if (s < ACC_MINV) begin m_acc = ACC_MINV; m_ov = 1; end
      else                   m_acc = s;
    end
    @(posedge clk);
    #1;
    check({tag, ".acc"}, int'(acc_out), m_acc);
    check({tag, ".ovf"}, int'(overflow), m_ov);
    check({tag, ".alu"}, int'(alu), e_alu);
    clear      = 1'b0;
    accumulate = 1'b0;
  endtask

  task automatic idle3(input string tag);
    for (int k = 0; k < 3; k++) run_edge(1'b0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    accumulate = 1'b0;
    set_ops(15, 15, 15, 15, 7, 7, 7, 7, 7);

    // Reset state before any clock edge
    #3;
    check("reset.acc", int'(acc_out), 0);
    check("reset.ovf", int'(overflow), 0);
    check("reset.alu", int'(alu), 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = 0;
    m_ov  = 0;

    // Single-accumulate vectors from a cleared accumulator
    vt[0] = '{i: '{15, 15, 15, 15}, wt: '{ 1,  1,  1,  1}, b:  0, exp_acc:   60, exp_alu:  9};
    vt[1] = '{i: '{15, 15, 15, 15}, wt: '{-8, -8, -8, -8}, b:  0, exp_acc: -480, exp_alu:  0};
    vt[2] = '{i: '{ 1,  2,  3,  4}, wt: '{ 1, -1,  2, -2}, b:  0, exp_acc:   -3, exp_alu:  7};
    vt[3] = '{i: '{15, 15, 15, 15}, wt: '{ 7,  7,  7,  7}, b:  7, exp_acc:  420, exp_alu: 15};
    vt[4] = '{i: '{ 0,  0,  0,  0}, wt: '{ 7,  7,  7,  7}, b: -8, exp_acc:    0, exp_alu:  4};
    vt[5] = '{i: '{10,  0,  5, 15}, wt: '{ 3,  7, -2,  0}, b:  2, exp_acc:   20, exp_alu:  9};
    vt[6] = '{i: '{ 0,  0,  0,  0}, wt: '{ 0,  0,  0,  0}, b: -1, exp_acc:    0, exp_alu:  7};
    vt[7] = '{i: '{ 0,  0,  0,  0}, wt: '{ 0,  0,  0,  0}, b:  7, exp_acc:    0, exp_alu: 11};

    for (int j = 0; j < 8; j++) begin
      set_ops(vt[j].i[0], vt[j].i[1], vt[j].i[2], vt[j].i[3],
              vt[j].wt[0], vt[j].wt[1], vt[j].wt[2], vt[j].wt[3], vt[j].b);
      run_edge(1'b1, 1'b0, $sformatf("vec%0d.clr", j));
      idle3($sformatf("vec%0d.fill", j));
      run_edge(1'b0, 1'b1, $sformatf("vec%0d.acc", j));
      check($sformatf("vec%0d.tbl_acc", j), int'(acc_out), vt[j].exp_acc);
      run_edge(1'b0, 1'b0, $sformatf("vec%0d.out", j));
      check($sformatf("vec%0d.tbl_alu", j), int'(alu), vt[j].exp_alu);
    end

    // Collision: clear and accumulate together discard the partial sum
    set_ops(15, 15, 15, 15, 1, 1, 1, 1, 0);
    run_edge(1'b1, 1'b0, "coll.clr");
    idle3("coll.fill");
    run_edge(1'b0, 1'b1, "coll.acc");
    check("coll.acc60", int'(acc_out), 60);
    run_edge(1'b1, 1'b1, "coll.both");
    check("coll.zero", int'(acc_out), 0);

    // Saturation at the positive limit, hold, step back off, then clear
    set_ops(15, 15, 15, 15, 7, 7, 7, 7, 0);
    run_edge(1'b1, 1'b0, "sat.clr");
    idle3("sat.fill");
    for (int k = 0; k < 78; k++) run_edge(1'b0, 1'b1, "sat.run");
    check("sat.78_acc", int'(acc_out), 32760);
    check("sat.78_ovf", int'(overflow), 0);
    run_edge(1'b0, 1'b1, "sat.79");
    check("sat.79_acc", int'(acc_out), 32767);
    check("sat.79_ovf", int'(overflow), 1);
    run_edge(1'b0, 1'b1, "sat.hold");
    check("sat.hold_acc", int'(acc_out), 32767);
    set_ops(15, 15, 15, 15, -8, -8, -8, -8, 0);
    idle3("sat.turn");
    run_edge(1'b0, 1'b1, "sat.down");
    check("sat.down_acc", int'(acc_out), 32287);
    check("sat.down_ovf", int'(overflow), 1);
    run_edge(1'b1, 1'b0, "sat.clear");
    check("sat.clear_acc", int'(acc_out), 0);
    check("sat.clear_ovf", int'(overflow), 0);

    // Negative saturation
    for (int k = 0; k < 69; k++) run_edge(1'b0, 1'b1, "nsat.run");
    check("nsat.acc", int'(acc_out), -32768);
    check("nsat.ovf", int'(overflow), 1);

    // Reset mid-accumulation flushes pipeline; post-release zero operands add nothing
    set_ops(15, 15, 15, 15, 7, 7, 7, 7, 3);
    run_edge(1'b1, 1'b0, "rmid.clr");
    idle3("rmid.fill");
    run_edge(1'b0, 1'b1, "rmid.acc");
    #2;
    rst = 1'b1;
    #1;
    check("rmid.async_acc", int'(acc_out), 0);
    check("rmid.async_ovf", int'(overflow), 0);
    check("rmid.async_alu", int'(alu), 0);
    m_acc = 0;
    m_ov  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_edge(1'b0, 1'b1, "rmid.post1");
    check("rmid.post1_acc", int'(acc_out), 0);
    run_edge(1'b0, 1'b1, "rmid.post2");
    run_edge(1'b0, 1'b1, "rmid.post3");

    // Randomized transactions against the model
    for (int t = 0; t < 120; t++) begin
      set_ops($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15),
              int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
              int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
              int'($urandom_range(15)) - 8);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(3) == 0) bias = 4'($urandom_range(15));
        run_edge(1'b0, 1'b0, "rnd.idle");
      end
      run_edge(1'($urandom_range(9) == 0), 1'($urandom_range(9) < 7), "rnd.op");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_alu.md
NEURON_ALU -- requirements
Module: neuron_alu

Interface
REQ-001 Parameter ACC_WIDTH, default 16: signed accumulator width in bits.
REQ-002 Parameter OUT_SHIFT, default 5: arithmetic right shift applied before activation.
REQ-003 Parameter OUT_OFFSET, default 8: offset added after the shift.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 clear  in  1  zero the accumulator and the overflow flag.
REQ-008 accumulate  in  1  add the current partial sum into the accumulator.
REQ-009 weight1..weight4  in  4 each  signed two's-complement weights, range -8..7.
REQ-010 input1..input4  in  4 each  unsigned activations, range 0..15.
REQ-011 bias  in  4  signed two's-complement neuron bias.
REQ-012 ALUOutput  out  4  registered activated neuron value, 0..15.
REQ-013 acc_out  out  ACC_WIDTH  current accumulator value, signed.
REQ-014 overflow  out  1  sticky saturation flag.

Function
REQ-015 Stage 1 SHALL, every cycle, register p_i = {0,input_i} x weight_i for i = 1..4, each as a signed 9-bit value.
REQ-016 Stage 2 SHALL, every cycle, register psum = p1+p2+p3+p4 as a signed 11-bit value (range -480..420).
REQ-017 Operands stable at edge E SHALL appear in psum after edge E+2; accumulate asserted in the cycle after E+2 SHALL use those operands.
REQ-018 clear=1 SHALL set acc to 0 and overflow to 0 at the next edge.
REQ-019 When clear=0 and accumulate=1, acc SHALL become sat(acc + sext(psum)).
REQ-020 When clear=0 and accumulate=0, acc SHALL hold its value.
REQ-021 When clear and accumulate are both 1, clear SHALL win and psum SHALL be discarded.
REQ-022 Saturation limits are +2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1).
- A sum that exceeds a limit SHALL clamp to that limit and set overflow=1.
- overflow SHALL stay 1 until clear or rst.
REQ-023 A saturated acc SHALL remain at its limit on further same-sign accumulates.
- An opposite-sign accumulate SHALL move acc off the limit normally.
REQ-024 total SHALL be acc + (sext(bias) <<< 4), computed at ACC_WIDTH+1 bits with no saturation.
REQ-025 ALUOutput SHALL be registered as clamp((total >>> OUT_SHIFT) + OUT_OFFSET, 0, 15).
- The shift is arithmetic, i.e. floor toward minus infinity.
REQ-026 ALUOutput latency:
- It SHALL reflect acc and bias one edge after acc updates.
- It SHALL update every cycle, including while clear or accumulate are idle.
REQ-027 acc_out SHALL be driven combinationally from the accumulator register.
REQ-028 Weight, input or bias changes SHALL NOT affect acc unless accumulate is asserted; bias SHALL affect only total and ALUOutput.
REQ-029 The block SHALL have no internal FSM beyond the fixed pipeline; sequencing SHALL be driven entirely by clear and accumulate.

Reset
REQ-030 While rst=1, the following SHALL all be 0: p1..p4, psum, acc, acc_out, overflow, ALUOutput.
REQ-031 rst asserted mid-accumulation SHALL discard all pipeline contents.
- The first accumulate after release SHALL use only operands presented after release, once REQ-017 latency has elapsed.

Verification
REQ-032 Reset: assert rst with nonzero operands -> acc_out=0, overflow=0, ALUOutput=0 immediately, without waiting for an edge.
REQ-033 Positive: clear; inputs 15,15,15,15; weights 1,1,1,1; bias 0; accumulate once after 2 cycles -> acc_out=60; next edge ALUOutput=9.
REQ-034 Negative clamp: inputs 15x4, weights -8x4, bias 0, one accumulate -> acc_out=-480; ALUOutput=0.
REQ-035 Saturation: inputs 15x4, weights 7x4 (psum 420), accumulate 78 cycles -> acc_out=32760, overflow=0; 79th -> 32767, overflow=1; then clear -> acc_out=0, overflow=0.
REQ-036 Collision: acc_out=60, then clear=1 and accumulate=1 in the same cycle -> acc_out=0.
REQ-037 Bias only, acc_out=0:
- bias=-1 -> ALUOutput=7.
- bias=7 -> ALUOutput=11.
- bias=-8 -> ALUOutput=4.
